wb_master_arbiter: RTL and testbench

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_arb_pkg.sv | 31 +++
 rtl/arb_rr.sv | 34 +++
 rtl/wb_master_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the Wishbone B3 master arbiter.
//   arb_state_t     : arbiter FSM state encoding
//   CTI_*           : Wishbone cycle-type identifiers
//   onehot_to_idx() : converts a one-hot grant (up to 8 masters) to an index
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ABORT  = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Index of the set bit; 0 for an all-zero vector.
    function automatic int onehot_to_idx(input logic [7:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr.sv
// ---------------------------------------------------------------------------
// arb_rr
// Combinational round-robin pick. The search starts at the master after
// i_last_grant and wraps around, so the most recently served master has
// the lowest priority.
//   i_req        in  MASTERS  request vector (m_cyc_i)
//   i_last_grant in  IDX_W    index of the master served last
//   o_grant      out MASTERS  one-hot pick, zero when nothing requests
// ---------------------------------------------------------------------------
module arb_rr #(
    parameter int MASTERS = 2,
    parameter int IDX_W   = 1
) (
    input  logic [MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [MASTERS-1:0] o_grant
);

    always_comb begin
        int   idx;
        logic found;
        o_grant = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 1; off <= MASTERS; off++) begin
            idx = (int'(i_last_grant) + off) % MASTERS;
            if (!found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter
// Shares one Wishbone B3 bus port between MASTERS masters. A master keeps
// the bus for its whole cycle (bursts included) until it drops m_cyc_i.
// Every handoff passes through one idle cycle. A watchdog aborts a strobed
// access that sees no ack/err/rty for TIMEOUT cycles and returns an error
// to the owning master.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   m_adr_i/m_dat_i/m_sel_i       per-master address, write data, byte sel
//   m_we_i/m_cyc_i/m_stb_i        per-master write enable, cycle, strobe
//   m_cti_i/m_bte_i               per-master cycle type, burst type
//   m_dat_o                       read data, s_dat_i broadcast to all slices
//   m_ack_o/m_err_o/m_rty_o       per-master terminations
//   s_*_o                         bus-side request from the granted master
//   s_dat_i/s_ack_i/s_err_i/s_rty_i  bus-side response
//   grant_o                       one-hot current grant, zero when idle
//   timeout_o                     one-cycle pulse on a watchdog abort
//
// State     | meaning
// ----------+----------------------------------------------------------------
// ST_IDLE   | bus released; pick the next requester round-robin
// ST_ACTIVE | granted master drives the bus; watchdog counts stalled cycles
// ST_ABORT  | one cycle: bus dropped, error returned to the granted master
// ---------------------------------------------------------------------------
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int MASTERS    = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 255,
    localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic [ADDR_WIDTH*MASTERS-1:0]   m_adr_i,
    input  logic [DATA_WIDTH*MASTERS-1:0]   m_dat_i,
    input  logic [SEL_WIDTH*MASTERS-1:0]    m_sel_i,
    input  logic [MASTERS-1:0]              m_we_i,
    input  logic [MASTERS-1:0]              m_cyc_i,
    input  logic [MASTERS-1:0]              m_stb_i,
    input  logic [3*MASTERS-1:0]            m_cti_i,
    input  logic [2*MASTERS-1:0]            m_bte_i,
    output logic [DATA_WIDTH*MASTERS-1:0]   m_dat_o,
    output logic [MASTERS-1:0]              m_ack_o,
    output logic [MASTERS-1:0]              m_err_o,
    output logic [MASTERS-1:0]              m_rty_o,

    output logic [ADDR_WIDTH-1:0]           s_adr_o,
    output logic [DATA_WIDTH-1:0]           s_dat_o,
    output logic [SEL_WIDTH-1:0]            s_sel_o,
    output logic                            s_we_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic [2:0]                      s_cti_o,
    output logic [1:0]                      s_bte_o,
    input  logic [DATA_WIDTH-1:0]           s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic                            s_rty_i,

    output logic [MASTERS-1:0]              grant_o,
    output logic                            timeout_o
);

    localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [MASTERS-1:0]  r_grant;
    logic [MASTERS-1:0]  w_grant_nxt;
    logic [IDX_W-1:0]    r_last;
    logic [IDX_W-1:0]    w_last_nxt;
    logic [15:0]         r_wdog;
    logic [15:0]         w_wdog_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;

    logic [MASTERS-1:0]  w_rr_grant;
    logic [IDX_W-1:0]    w_gidx;

    logic [ADDR_WIDTH-1:0] w_adr;
    logic [DATA_WIDTH-1:0] w_dat;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic                  w_we;
    logic                  w_cyc;
    logic                  w_stb;
    logic [2:0]            w_cti;
    logic [1:0]            w_bte;
    logic                  w_term;
    logic                  w_stall;

    arb_rr #(
        .MASTERS (MASTERS),
        .IDX_W   (IDX_W)
    ) u_arb_rr (
        .i_req        (m_cyc_i),
        .i_last_grant (r_last),
        .o_grant      (w_rr_grant)
    );

    assign w_gidx    = IDX_W'(onehot_to_idx(8'(r_grant)));
    assign m_dat_o   = {MASTERS{s_dat_i}};
    assign grant_o   = r_grant;
    assign timeout_o = r_timeout;

    // Grant is one-hot, so an AND-OR mux selects the owner's slice.
    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_sel = '0;
        w_we  = 1'b0;
        w_cyc = 1'b0;
        w_stb = 1'b0;
        w_cti = '0;
        w_bte = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (r_grant[m]) begin
                w_adr |= m_adr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
                w_dat |= m_dat_i[m*DATA_WIDTH +: DATA_WIDTH];
                w_sel |= m_sel_i[m*SEL_WIDTH +: SEL_WIDTH];
                w_we  |= m_we_i[m];
                w_cyc |= m_cyc_i[m];
                w_stb |= m_stb_i[m];
                w_cti |= m_cti_i[m*3 +: 3];
                w_bte |= m_bte_i[m*2 +: 2];
            end
        end
    end

    assign w_term  = s_ack_i | s_err_i | s_rty_i;
    assign w_stall = w_cyc & w_stb & ~w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_last    <= IDX_W'(MASTERS - 1);
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_wdog    <= w_wdog_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last;
        w_wdog_nxt    = '0;
        w_timeout_nxt = 1'b0;

        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;

        case (r_state)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    w_grant_nxt = w_rr_grant;
                    w_state_nxt = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                s_adr_o = w_adr;
                s_dat_o = w_dat;
                s_sel_o = w_sel;
                s_we_o  = w_we;
                s_cyc_o = w_cyc;
                s_stb_o = w_stb;
                s_cti_o = w_cti;
                s_bte_o = w_bte;
                m_ack_o = r_grant & {MASTERS{s_ack_i}};
                m_err_o = r_grant & {MASTERS{s_err_i}};
                m_rty_o = r_grant & {MASTERS{s_rty_i}};

                if (!w_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = w_gidx;
                end else if (w_stall) begin
                    // A termination in the final cycle clears w_stall, so
                    // a late ack always beats the watchdog.
                    if (r_wdog == 16'(TIMEOUT - 1)) begin
                        w_state_nxt   = ST_ABORT;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_wdog_nxt = r_wdog + 16'd1;
                    end
                end
            end

            ST_ABORT: begin
                // Bus outputs stay zero; the owner's m_cyc_i is ignored here.
                m_err_o     = r_grant;
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_last_nxt  = w_gidx;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;

    localparam int M  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;

    logic [M*AW-1:0] m_adr_i;
    logic [M*DW-1:0] m_dat_i;
    logic [M*SW-1:0] m_sel_i;
    logic [M-1:0]    m_we_i, m_cyc_i, m_stb_i;
    logic [3*M-1:0]  m_cti_i;
    logic [2*M-1:0]  m_bte_i;
    logic [M*DW-1:0] m_dat_o;
    logic [M-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i, s_rty_i;
    logic [M-1:0]    grant_o;
    logic            timeout_o;

    wb_master_arbiter #(
        .MASTERS    (M),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_we_i    (m_we_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_cti_i   (m_cti_i),
        .m_bte_i   (m_bte_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_rty_o   (m_rty_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_cti_o   (s_cti_o),
        .s_bte_o   (s_bte_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .s_rty_i   (s_rty_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level model: who owns the bus, who was served last, and
    // how long the owner has been waiting. md: 0 free, 1 owned, 2 aborting.
    int md, own, last, wcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md = 0; own = 0; last = M - 1; wcnt = 0;
    endtask

    function automatic int pick_next(input logic [M-1:0] req, input int after);
        for (int k = 1; k <= M; k++) begin
            if (req[(after + k) % M]) return (after + k) % M;
        end
        return -1;
    endfunction

    // Compare every output against the model for the current cycle, then
    // advance the model with this cycle's inputs.
    task automatic tick();
        logic [M-1:0]  eg, eack, eerr, erty;
        logic          ecyc, estb, ewe, eto;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat;
        logic [SW-1:0] esel;
        logic [2:0]    ecti;
        logic [1:0]    ebte;
        @(negedge clk);
        eg = '0; eack = '0; eerr = '0; erty = '0;
        ecyc = 0; estb = 0; ewe = 0; eto = 0;
        eadr = '0; edat = '0; esel = '0; ecti = '0; ebte = '0;
        if (md == 1) begin
            eg[own] = 1'b1;
            ecyc = m_cyc_i[own];
            estb = m_stb_i[own];
            ewe  = m_we_i[own];
            eadr = m_adr_i[own*AW +: AW];
            edat = m_dat_i[own*DW +: DW];
            esel = m_sel_i[own*SW +: SW];
            ecti = m_cti_i[own*3 +: 3];
            ebte = m_bte_i[own*2 +: 2];
            eack[own] = s_ack_i;
            eerr[own] = s_err_i;
            erty[own] = s_rty_i;
        end else if (md == 2) begin
            eg[own]   = 1'b1;
            eerr[own] = 1'b1;
            eto       = 1'b1;
        end
        chk("grant", grant_o, eg);
        chk("s_cyc", s_cyc_o, ecyc);
        chk("s_stb", s_stb_o, estb);
        chk("s_we", s_we_o, ewe);
        chk("s_adr", s_adr_o, eadr);
        chk("s_dat", s_dat_o, edat);
        chk("s_sel", s_sel_o, esel);
        chk("s_cti", s_cti_o, ecti);
        chk("s_bte", s_bte_o, ebte);
        chk("m_ack", m_ack_o, eack);
        chk("m_err", m_err_o, eerr);
        chk("m_rty", m_rty_o, erty);
        chk("timeout", timeout_o, eto);
        chk("m_dat", m_dat_o, {M{s_dat_i}});

        if (md == 0) begin
            if (|m_cyc_i) begin
                own = pick_next(m_cyc_i, last); md = 1; wcnt = 0;
            end
        end else if (md == 1) begin
            if (!m_cyc_i[own]) begin
                md = 0; last = own;
            end else if (m_stb_i[own] && !(s_ack_i || s_err_i || s_rty_i)) begin
                wcnt++;
                if (wcnt == TO) begin md = 2; wcnt = 0; end
            end else begin
                wcnt = 0;
            end
        end else begin
            md = 0; last = own;
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb,
                         input logic [AW-1:0] adr, input logic [2:0] cti);
        m_cyc_i[m] = cyc;
        m_stb_i[m] = stb;
        m_adr_i[m*AW +: AW] = adr;
        m_cti_i[m*3 +: 3] = cti;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int quiet;
        int r;
        rst_n = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
        m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
        model_reset();

        // Reset state, with requests already present.
        m_cyc_i = 2'b11;
        nxt();
        @(negedge clk);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_scyc", s_cyc_o, 1'b0);
        chk("rst_sadr", s_adr_o, 32'h0);
        chk("rst_timeout", timeout_o, 1'b0);
        chk("rst_ack", m_ack_o, 2'b00);

        // Both request at cycle 0 -> master 0 first, idle gap, then master 1.
        nxt();
        rst_n = 1'b1;
        set_m(0, 1, 0, 32'h0000_1000, 3'b000);
        set_m(1, 1, 0, 32'h0000_2000, 3'b000);
        tick();
        chk("r025_c0_grant", grant_o, 2'b00);
        nxt(); tick();
        chk("r025_c1_grant", grant_o, 2'b01);
        chk("r025_c1_scyc", s_cyc_o, 1'b1);
        nxt(); set_m(0, 0, 0, 32'h0, 3'b000); tick();
        nxt(); tick();
        chk("r025_gap_scyc", s_cyc_o, 1'b0);
        chk("r025_gap_grant", grant_o, 2'b00);
        nxt(); tick();
        chk("r025_m1_grant", grant_o, 2'b10);
        nxt(); set_m(1, 0, 0, 32'h0, 3'b000); tick();
        nxt(); tick();

        // 4-beat INCR burst on master 0 while master 1 waits.
        nxt();
        set_m(0, 1, 1, 32'h0000_0100, 3'b010);
        set_m(1, 1, 1, 32'h0000_0200, 3'b000);
        tick();
        for (int b = 0; b < 4; b++) begin
            nxt();
            s_ack_i = 1'b1;
            set_m(0, 1, 1, 32'h0000_0100 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
            tick();
            chk("r026_grant", grant_o, 2'b01);
            chk("r026_ack", m_ack_o, 2'b01);
        end
        nxt(); s_ack_i = 1'b0; set_m(0, 0, 0, 32'h0, 3'b000); tick();
        nxt(); tick();
        chk("r026_gap_grant", grant_o, 2'b00);

        // Master 1 strobes with no response: 8 stalls, then one abort cycle.
        for (int s = 0; s < TO; s++) begin
            nxt(); tick();
            chk("r027_stall_grant", grant_o, 2'b10);
            chk("r027_stall_to", timeout_o, 1'b0);
        end
        nxt(); set_m(1, 0, 0, 32'h0, 3'b000); tick();
        chk("r027_abort_err", m_err_o, 2'b10);
        chk("r027_abort_to", timeout_o, 1'b1);
        chk("r027_abort_scyc", s_cyc_o, 1'b0);
        nxt(); tick();
        chk("r027_idle_grant", grant_o, 2'b00);
        chk("r027_idle_to", timeout_o, 1'b0);

        // Ack lands on the 8th stalled cycle: ack wins, no abort.
        nxt(); set_m(0, 1, 1, 32'h0000_0300, 3'b000); tick();
        for (int s = 0; s < TO - 1; s++) begin
            nxt(); tick();
        end
        nxt(); s_ack_i = 1'b1; tick();
        chk("r028_ack", m_ack_o, 2'b01);
        chk("r028_err", m_err_o, 2'b00);
        chk("r028_to", timeout_o, 1'b0);
        nxt(); s_ack_i = 1'b0; set_m(0, 0, 0, 32'h0, 3'b000); tick();
        nxt(); tick();
        chk("r028_after_to", timeout_o, 1'b0);
        chk("r028_after_grant", grant_o, 2'b00);

        // Asynchronous reset in the middle of an access.
        nxt(); set_m(0, 1, 1, 32'h8000_0010, 3'b000); tick();
        nxt(); tick();
        chk("r029_adr", s_adr_o, 32'h8000_0010);
        nxt();
        #2;
        rst_n = 1'b0;
        #1;
        chk("r029_async_scyc", s_cyc_o, 1'b0);
        chk("r029_async_grant", grant_o, 2'b00);
        chk("r029_async_ack", m_ack_o, 2'b00);
        model_reset();
        set_m(1, 1, 0, 32'h0000_0400, 3'b000);
        nxt();
        nxt();
        rst_n = 1'b1;
        tick();
        nxt(); tick();
        chk("r029_first_grant", grant_o, 2'b01);

        // Random traffic against the model; quiet phases provoke timeouts.
        quiet = 0;
        for (int c = 0; c < 600; c++) begin
            nxt();
            if (c % 40 == 0) quiet = (quiet == 0) ? 1 : 0;
            for (int m = 0; m < M; m++) begin
                if (m_cyc_i[m]) begin
                    if ($urandom_range(0, (quiet != 0) ? 30 : 5) == 0) m_cyc_i[m] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    m_cyc_i[m] = 1'b1;
                end
                m_stb_i[m] = m_cyc_i[m] & ((quiet != 0) || ($urandom_range(0, 3) != 0));
                m_adr_i[m*AW +: AW] = $urandom;
                m_dat_i[m*DW +: DW] = $urandom;
                m_sel_i[m*SW +: SW] = SW'($urandom);
                m_we_i[m]           = 1'($urandom);
                m_cti_i[m*3 +: 3]   = 3'($urandom);
                m_bte_i[m*2 +: 2]   = 2'($urandom);
            end
            s_dat_i = $urandom;
            r = $urandom_range(0, 9);
            s_ack_i = (quiet == 0) && (r < 4);
            s_err_i = (quiet == 0) && (r == 4);
            s_rty_i = (quiet == 0) && (r == 5);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
